// File: rtl/inst_fetch_buf.sv
// -----------------------------------------------------------------------------
// inst_fetch_buf
//   Prefetch FIFO between the PC register / instruction ROM and the ID stage.
//   Each fetched {pc, inst} pair is captured and presented to decode through a
//   valid/ready handshake. Fetch is back-pressured when the buffer is full so
//   the PC can stall without losing instructions. A flush drops every entry.
//
// Parameters
//   DEPTH  number of buffered entries (power of two, >= 2)
//   AW     pointer width, log2(DEPTH)
//
// Ports
//   clk       clock, all state updates on posedge
//   rst       synchronous, active-high reset
//   if_valid  fetch slot carries a valid instruction
//   if_pc     address of the fetched instruction
//   if_inst   instruction word from the ROM
//   if_ready  buffer accepts a push this cycle (low = hold the PC)
//   id_valid  head entry is valid for decode
//   id_pc     PC of the head entry (0 when empty)
//   id_inst   instruction of the head entry (0 when empty)
//   id_ready  decode consumes the head entry this cycle
//   flush     discard all entries (branch taken / exception)
//   count     current occupancy, 0..DEPTH
//
// Build option
//   IFB_BYPASS_EN  when defined, an instruction arriving at an empty buffer
//                  that decode accepts in the same cycle passes straight
//                  through combinationally and is never stored.
// -----------------------------------------------------------------------------
module inst_fetch_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_inst,
  output logic          if_ready,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_inst,
  input  logic          id_ready,
  input  logic          flush,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Storage is data only; it is never reset.
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic empty;
  logic full;
  logic bypass;
  logic wr_en;
  logic rd_en;

  always_comb begin
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    if_ready = ~rst & ~full;
`ifdef IFB_BYPASS_EN
    // Empty buffer and decode ready: hand the fetch slot straight through.
    bypass   = empty & if_valid & id_ready & ~flush & ~rst;
`else
    bypass   = 1'b0;
`endif
    // A bypassed instruction is consumed by decode, so it is not stored.
    wr_en    = if_valid & if_ready & ~flush & ~bypass;
    rd_en    = ~empty & id_ready & ~flush;
    id_valid = (~empty & ~flush) | bypass;
  end

  // Head-of-queue output mux; zero when nothing is buffered.
  always_comb begin
    id_pc   = 32'h0;
    id_inst = 32'h0;
`ifdef IFB_BYPASS_EN
    if (bypass) begin
      id_pc   = if_pc;
      id_inst = if_inst;
    end else if (!empty) begin
      id_pc   = mem[rd_ptr][63:32];
      id_inst = mem[rd_ptr][31:0];
    end
`else
    if (!empty) begin
      id_pc   = mem[rd_ptr][63:32];
      id_inst = mem[rd_ptr][31:0];
    end
`endif
  end

  // Control state: flush clears exactly like reset, and wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry write; wr_en is already blocked during reset and flush.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {if_pc, if_inst};
  end

endmodule
